// File: rtl/mem_lsu.sv
// Load/store unit: byte-lane alignment, misalignment traps and access/stall counters for the core.
// Latency: accept -> REQ (1 cycle min) -> [WAIT] -> RESP; misaligned ops trap via EXC after 2 cycles.
// Backpressure: one op in flight; req_ready low until the response handshakes; REQ holds until Mem_Req_Ready.
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  // core request port
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_rt,
  // core response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_exc,
  // memory port
  output logic [ADDR_W-1:0]   Address,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [DATA_W-1:0]   Write_data,
  output logic [DATA_W/8-1:0] Write_strb,
  input  logic                Mem_Req_Ready,
  input  logic [DATA_W-1:0]   Read_data,
  input  logic                Read_data_Valid,
  output logic                Read_data_Ready,
  // performance counters
  output logic [CNT_W-1:0]    cnt_access,
  output logic [CNT_W-1:0]    cnt_stall
);

  localparam int NB = DATA_W / 8;
  localparam int NG = DATA_W / 32;

  // op[2:0] size/kind encoding (bit 3 of the opcode selects store)
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_WL = 3'b010;
  localparam logic [2:0] SZ_W  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WR = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXC,
    S_RESP
  } state_t;

  state_t state;

  // captured operation; k_q is the byte offset in the word, grp_q the 32-bit group on a 64-bit bus
  logic [3:0]  op_q;
  logic [1:0]  k_q;
  logic        grp_q;
  logic [31:0] rt_q;

  // accept-time decode of the incoming request
  logic [1:0]        in_k;
  logic              in_g;
  logic              in_mis;
  logic [31:0]       st_word;
  logic [3:0]        st_strb4;
  logic [DATA_W-1:0] st_data_bus;
  logic [NB-1:0]     st_strb_bus;
  logic [ADDR_W-1:0] in_addr_al;

  // load path decode from captured registers and the returning bus data
  logic [31:0] rd_word;
  logic [15:0] ld_lane;
  logic [31:0] ld_res;

  // Decode the incoming request: misalignment, aligned address, store lanes and strobes.
  always_comb begin
    in_k        = req_addr[1:0];
    in_g        = (DATA_W == 64) ? req_addr[2] : 1'b0;
    in_addr_al  = req_addr & ~ADDR_W'(NB - 1);
    // halfwords need an even address, full words need a 4-byte aligned one; wl/wr/b never trap
    in_mis      = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_op[2:0] == SZ_W) && (req_addr[1:0] != 2'b00));
    st_word     = req_rt;
    st_strb4    = 4'b0000;
    case (req_op[2:0])
      SZ_B: begin
        st_word  = {4{req_rt[7:0]}};
        st_strb4 = 4'b0001 << in_k;
      end
      SZ_H: begin
        st_word  = {2{req_rt[15:0]}};
        st_strb4 = 4'b0011 << in_k;
      end
      SZ_WL: begin
        // swl writes the high-order bytes of rt into lanes 0..k
        st_word = req_rt >> {~in_k, 3'b000};
        case (in_k)
          2'd0:    st_strb4 = 4'b0001;
          2'd1:    st_strb4 = 4'b0011;
          2'd2:    st_strb4 = 4'b0111;
          default: st_strb4 = 4'b1111;
        endcase
      end
      SZ_W: begin
        st_word  = req_rt;
        st_strb4 = 4'b1111;
      end
      SZ_WR: begin
        // swr writes the low-order bytes of rt into lanes k..3
        st_word  = req_rt << {in_k, 3'b000};
        st_strb4 = 4'b1111 << in_k;
      end
      default: begin
        // undefined store encodings write nothing
        st_word  = req_rt;
        st_strb4 = 4'b0000;
      end
    endcase
    // data is replicated into every 32-bit group; only the selected group is strobed
    st_data_bus = {NG{st_word}};
    st_strb_bus = NB'(st_strb4) << {in_g, 2'b00};
  end

  // Extract, shift and extend the load result from the selected 32-bit group.
  always_comb begin
    rd_word = Read_data[31:0];
    if ((DATA_W == 64) && grp_q) begin
      rd_word = Read_data[DATA_W-1 -: 32];
    end
    ld_lane = 16'(rd_word >> {k_q, 3'b000});
    ld_res  = rd_word;
    case (op_q[2:0])
      SZ_B:  ld_res = {{24{ld_lane[7]}}, ld_lane[7:0]};
      SZ_BU: ld_res = {24'h000000, ld_lane[7:0]};
      SZ_H:  ld_res = {{16{ld_lane[15]}}, ld_lane[15:0]};
      SZ_HU: ld_res = {16'h0000, ld_lane[15:0]};
      // lwl merges the low bytes of the word into the top of rt
      SZ_WL: ld_res = (rd_word << {~k_q, 3'b000}) |
                      (rt_q & ~(32'hFFFF_FFFF << {~k_q, 3'b000}));
      // lwr merges the high bytes of the word into the bottom of rt
      SZ_WR: ld_res = (rd_word >> {k_q, 3'b000}) |
                      (rt_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
      default: ld_res = rd_word;
    endcase
  end

  // Control FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_data        <= 32'h0;
      rsp_exc         <= 1'b0;
      MemRead         <= 1'b0;
      MemWrite        <= 1'b0;
      Read_data_Ready <= 1'b0;
      Address         <= '0;
      Write_data      <= '0;
      Write_strb      <= '0;
      op_q            <= 4'h0;
      k_q             <= 2'b00;
      grp_q           <= 1'b0;
      rt_q            <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            k_q       <= in_k;
            grp_q     <= in_g;
            rt_q      <= req_rt;
            req_ready <= 1'b0;
            rsp_data  <= 32'h0;
            if (in_mis) begin
              state <= S_EXC;
            end else begin
              state      <= S_REQ;
              Address    <= in_addr_al;
              MemRead    <= ~req_op[3];
              MemWrite   <= req_op[3];
              Write_data <= st_data_bus;
              Write_strb <= req_op[3] ? st_strb_bus : '0;
            end
          end
        end
        S_REQ: begin
          // request outputs stay frozen until memory takes them
          if (Mem_Req_Ready) begin
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Write_strb <= '0;
            if (op_q[3]) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state           <= S_WAIT;
              Read_data_Ready <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (Read_data_Valid) begin
            rsp_data        <= ld_res;
            Read_data_Ready <= 1'b0;
            rsp_valid       <= 1'b1;
            state           <= S_RESP;
          end
        end
        S_EXC: begin
          rsp_valid <= 1'b1;
          rsp_exc   <= 1'b1;
          rsp_data  <= 32'h0;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_exc   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Access and stall counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_access <= '0;
      cnt_stall  <= '0;
    end else begin
      if ((state == S_REQ) && Mem_Req_Ready) begin
        cnt_access <= cnt_access + CNT_W'(1);
      end
      if ((state == S_REQ) || (state == S_WAIT)) begin
        cnt_stall <= cnt_stall + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit for the multi-cycle custom CPU.
- Moves the memory request/response handshakes and all byte-lane alignment out of the core datapath.
- Supports lb/lbu/lh/lhu/lw/lwl/lwr/sb/sh/sw/swl/swr on a 32- or 64-bit memory bus, with misalignment exception detection and access/stall counters.
- The core hands over one operation at a time through a valid/ready port and receives the result (or exception) through a valid/ready response port.

Parameters:
- DATA_W, 32: memory bus width; legal values 32 or 64. Byte lanes: NB = DATA_W/8.
- ADDR_W, 32: byte address width.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an operation.
- req_ready  out  1  unit accepts an operation; high only in IDLE.
- req_op  in  4  MIPS opcode[3:0]. Bit3 = store. [2:0]: 000 b, 001 h, 010 wl, 011 w, 100 bu, 101 hu, 110 wr.
- req_addr  in  ADDR_W  effective byte address.
- req_rt  in  32  rt value: store data, or merge source for lwl/lwr.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  core accepts result.
- rsp_data  out  32  load result; 0 for stores and exceptions.
- rsp_exc  out  1  misaligned-address exception.
- Address  out  ADDR_W  memory address, aligned to NB.
- MemWrite  out  1  store request.
- MemRead  out  1  load request.
- Write_data  out  DATA_W  lane-aligned store data.
- Write_strb  out  NB  byte strobes.
- Mem_Req_Ready  in  1  memory accepts the request.
- Read_data  in  DATA_W  load data.
- Read_data_Valid  in  1  load data valid.
- Read_data_Ready  out  1  unit accepts load data.
- cnt_access  out  CNT_W  completed memory accesses.
- cnt_stall  out  CNT_W  cycles spent in REQ or WAIT.

Behaviour:
- Reset (rst synchronous, active-high; clk rising edge):
  - State goes to IDLE; counters clear.
  - req_ready=1. rsp_valid, MemRead, MemWrite, Read_data_Ready = 0.
  - rsp_data=0, rsp_exc=0, Write_strb=0.
  - Reset mid-operation abandons the access; the memory system shares rst.
- Capture: on req_valid&&req_ready, register op, addr and rt. All later outputs derive from the registers.
- Misalignment: h/hu with addr[0]=1, or w with addr[1:0]!=0 → state EXC. No memory request is issued. wl/wr and b are never misaligned.
- States:
  - IDLE → REQ on a valid, aligned accept; → EXC on a misaligned accept.
  - REQ: MemRead = load, MemWrite = store. Address={addr[ADDR_W-1:log2 NB], 0s}.
    - Load with Mem_Req_Ready → WAIT.
    - Store with Mem_Req_Ready → RESP.
    - Otherwise hold all outputs stable.
  - WAIT: Read_data_Ready=1. On Read_data_Valid, latch the aligned/extended result → RESP.
  - EXC → RESP with rsp_exc=1 and rsp_data=0.
  - RESP: rsp_valid=1, held until rsp_ready, then → IDLE. req_ready is 0 during RESP, so there is no back-to-back overlap.
- Lane selection:
  - w = selected 32-bit group, index addr[2] when DATA_W=64, otherwise 0.
  - k = addr[1:0] within that word.
  - All shifts and strobes below are applied inside word w. The other group's strobes are 0.
- Store data and strobes:
  - sb: data = rt[7:0] replicated; strb = 1<<k.
  - sh: data = rt[15:0] replicated; strb = 3<<k.
  - sw: data = rt; strb = 4'hF.
  - swl: data = rt>>(8*(3-k)); strb = (1<<(k+1))-1.
  - swr: data = rt<<(8*k); strb = 4'hF<<k.
- Load result (W = selected word):
  - b/bu: W[8k+7:8k], sign- or zero-extended.
  - h/hu: W[8k+15:8k], sign- or zero-extended.
  - w: W.
  - lwl: (W<<8*(3-k)) | (rt & ~(32'hFFFFFFFF<<8*(3-k))).
  - lwr: (W>>8*k) | (rt & ~(32'hFFFFFFFF>>8*k)).
- Counters:
  - cnt_access increments on each REQ→WAIT or REQ→RESP transition.
  - cnt_stall increments every cycle in REQ or WAIT.
  - Both wrap at 2^CNT_W.
- Stall handling: Read_data_Valid arriving in the same cycle the state enters WAIT is not sampled. Data is sampled only while in WAIT.

Test Plan:
- DATA_W=32, lw at addr 0x100, Read_data=0x8899AABB, Mem_Req_Ready delayed 3 cycles → Address 0x100, rsp_data 0x8899AABB, cnt_access=1, cnt_stall=5 (4 REQ + 1 WAIT).
- lb at addr 0x103, Read_data=0x80112233 → rsp_data 0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x00008011.
- swl at addr 0x201, rt=0xAABBCCDD → Write_strb 4'b0011, Write_data[15:0]=0xAABB. swr at 0x201 → strb 4'b1110, Write_data=0xBBCCDD00.
- lwl at 0x001, Read_data=0x44332211, rt=0xAABBCCDD → rsp_data 0x2211CCDD. lwr at 0x001 → 0xAA443322.
- lw at 0x102 → no MemRead asserted, rsp_valid with rsp_exc=1 and rsp_data=0, cnt_access unchanged.
- DATA_W=64, sh at 0x10E, rt=0x1234 → Address 0x108, Write_strb 8'hC0, Write_data[63:48]=0x1234. rsp_ready held low 4 cycles → rsp_valid stays high and req_ready stays 0. Also assert rst during WAIT → next cycle IDLE, all outputs at reset values.
